// File: rtl/io_scan_seq.sv
// Select sequencer for the 1024:1 mux / 1:1024 demux I/O datapath: walks a source/destination
// window one pair per clock and flags each transfer when the datapath's registered output is valid.
module io_scan_seq #(
    parameter int SEL_W    = 10,
    parameter int COM_W    = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SEL_W-1:0] src_base,
    input  logic [SEL_W-1:0] dst_base,
    input  logic [SEL_W:0]   len,
    input  logic [COM_W-1:0] com_cfg,
    output logic [SEL_W-1:0] mux_sel,
    output logic [SEL_W-1:0] demux_sel,
    output logic [COM_W-1:0] com_sel,
    output logic             busy,
    output logic             done,
    output logic             xfer_valid,
    output logic [SEL_W:0]   xfer_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [SEL_W:0] ONE = (SEL_W+1)'(1);

    state_t                      state, state_nxt;
    logic                        launch, issue;
    logic [SEL_W:0]              len_eff, len_r, cnt;
    logic [SEL_W-1:0]            src_cur, dst_cur;
    logic [PIPE_LAT:0]           vld_pipe;
    logic [PIPE_LAT:0][SEL_W:0]  idx_pipe;

    // A zero length means a full sweep of the address space.
    assign len_eff = (len == '0) ? {1'b1, {SEL_W{1'b0}}} : len;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = (len_eff == ONE) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (cnt == len_r - ONE) state_nxt = DRAIN;
                end
            end
            // The stage feeding xfer_valid may still be set; nothing earlier may be.
            DRAIN: begin
                if (vld_pipe[PIPE_LAT-1:0] == '0) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_r     <= '0;
            cnt       <= '0;
            src_cur   <= '0;
            dst_cur   <= '0;
            mux_sel   <= '0;
            demux_sel <= '0;
            com_sel   <= '0;
            vld_pipe  <= '0;
            idx_pipe  <= '0;
        end else begin
            state <= state_nxt;
            // The datapath XORs com_sel into the mux select, so pre-apply it here.
            if (launch) begin
                len_r     <= len_eff;
                cnt       <= ONE;
                com_sel   <= com_cfg;
                mux_sel   <= src_base ^ {{(SEL_W-COM_W){1'b0}}, com_cfg};
                demux_sel <= dst_base;
                src_cur   <= src_base + 1'b1;
                dst_cur   <= dst_base + 1'b1;
            end else if (issue) begin
                cnt       <= cnt + 1'b1;
                mux_sel   <= src_cur ^ {{(SEL_W-COM_W){1'b0}}, com_sel};
                demux_sel <= dst_cur;
                src_cur   <= src_cur + 1'b1;
                dst_cur   <= dst_cur + 1'b1;
            end
            vld_pipe[0] <= launch | issue;
            idx_pipe[0] <= launch ? '0 : cnt;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign xfer_valid = vld_pipe[PIPE_LAT];
    assign xfer_idx   = idx_pipe[PIPE_LAT];

endmodule

// File: tb/tb_io_scan_seq.sv
// Directed bench for io_scan_seq: windows, XOR pre-compensation, wrap, full sweep, abort and reset.
module tb_io_scan_seq;

    localparam int SEL_W = 10;
    localparam int COM_W = 3;
    localparam int PL    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [SEL_W-1:0] src_base = '0;
    logic [SEL_W-1:0] dst_base = '0;
    logic [SEL_W:0]   len = '0;
    logic [COM_W-1:0] com_cfg = '0;
    logic [SEL_W-1:0] mux_sel, demux_sel;
    logic [COM_W-1:0] com_sel;
    logic             busy, done, xfer_valid;
    logic [SEL_W:0]   xfer_idx;

    int tests = 0;
    int fails = 0;

    io_scan_seq #(.SEL_W(SEL_W), .COM_W(COM_W), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len), .com_cfg(com_cfg),
        .mux_sel(mux_sel), .demux_sel(demux_sel), .com_sel(com_sel),
        .busy(busy), .done(done), .xfer_valid(xfer_valid), .xfer_idx(xfer_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a start pulse; returns in cycle 1 of the scan.
    task automatic launch(input int src, input int dst, input int n, input int com);
        src_base = SEL_W'(src);
        dst_base = SEL_W'(dst);
        len      = (SEL_W+1)'(n);
        com_cfg  = COM_W'(com);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Checks every cycle of a launched scan of n transfers, ending in the first idle cycle.
    task automatic scan_check(input string tag, input int src, input int dst, input int n,
                              input int com);
        for (int c = 1; c <= n + PL + 1; c++) begin
            if (c <= n) begin
                chk({tag, " mux_sel"}, 32'(mux_sel), 32'(((src + c - 1) % 1024) ^ com));
                chk({tag, " demux_sel"}, 32'(demux_sel), 32'((dst + c - 1) % 1024));
            end
            chk({tag, " xfer_valid"}, 32'(xfer_valid), 32'(c >= 1 + PL && c <= n + PL));
            if (c >= 1 + PL && c <= n + PL)
                chk({tag, " xfer_idx"}, 32'(xfer_idx), 32'(c - 1 - PL));
            chk({tag, " done"}, 32'(done), 32'(c == n + PL + 1));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            tick();
        end
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        chk({tag, " done after"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk(tag, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst mux_sel", 32'(mux_sel), 32'd0);
        chk("rst demux_sel", 32'(demux_sel), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst xfer_valid", 32'(xfer_valid), 32'd0);
        chk("rst xfer_idx", 32'(xfer_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic window: selects 0..3 / 5..8, valids cycles 3-6, done cycle 7.
        launch(0, 5, 4, 0);
        scan_check("basic", 0, 5, 4, 0);

        // Back-to-back launch in the idle cycle right after the previous scan.
        launch(40, 60, 3, 2);
        scan_check("b2b", 40, 60, 3, 2);

        // XOR pre-compensation: 8^5 = 13, 9^5 = 12.
        launch(8, 0, 2, 5);
        chk("xor com_sel", 32'(com_sel), 32'd5);
        chk("xor mux0", 32'(mux_sel), 32'd13);
        tick();
        chk("xor mux1", 32'(mux_sel), 32'd12);
        chk("xor demux1", 32'(demux_sel), 32'd1);
        wait_done("xor done");

        // Address wrap.
        launch(1022, 1023, 3, 0);
        chk("wrap mux0", 32'(mux_sel), 32'd1022);
        chk("wrap dmx0", 32'(demux_sel), 32'd1023);
        tick();
        chk("wrap mux1", 32'(mux_sel), 32'd1023);
        chk("wrap dmx1", 32'(demux_sel), 32'd0);
        tick();
        chk("wrap mux2", 32'(mux_sel), 32'd0);
        chk("wrap dmx2", 32'(demux_sel), 32'd1);
        wait_done("wrap done");

        // Single transfer with abort in the launch cycle: start wins.
        abort = 1'b1;
        launch(7, 9, 1, 0);
        abort = 1'b0;
        scan_check("len1", 7, 9, 1, 0);

        // len=0 sweeps all 1024 addresses; done in cycle 1027.
        launch(100, 200, 0, 0);
        scan_check("full", 100, 200, 1024, 0);

        // Abort present at the edge that would issue idx 2; restart in RUN is ignored.
        launch(0, 0, 10, 0);
        chk("abort mux c1", 32'(mux_sel), 32'd0);
        src_base = SEL_W'(100);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort mux c2", 32'(mux_sel), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort mux c3", 32'(mux_sel), 32'd1);
        chk("abort dmx c3", 32'(demux_sel), 32'd1);
        chk("abort vld c3", 32'(xfer_valid), 32'd1);
        chk("abort idx c3", 32'(xfer_idx), 32'd0);
        chk("abort busy c3", 32'(busy), 32'd1);
        tick();
        chk("abort vld c4", 32'(xfer_valid), 32'd1);
        chk("abort idx c4", 32'(xfer_idx), 32'd1);
        chk("abort done c4", 32'(done), 32'd0);
        tick();
        chk("abort vld c5", 32'(xfer_valid), 32'd0);
        chk("abort done c5", 32'(done), 32'd1);
        tick();
        chk("abort busy c6", 32'(busy), 32'd0);
        chk("abort done c6", 32'(done), 32'd0);

        // Reset mid-RUN discards in-flight transfers.
        launch(0, 0, 10, 3);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst mux_sel", 32'(mux_sel), 32'd0);
        chk("mrst demux_sel", 32'(demux_sel), 32'd0);
        chk("mrst com_sel", 32'(com_sel), 32'd0);
        chk("mrst xfer_idx", 32'(xfer_idx), 32'd0);
        chk("mrst done", 32'(done), 32'd0);
        for (int c = 0; c < 6; c++) begin
            chk("mrst busy", 32'(busy), 32'd0);
            chk("mrst xfer_valid", 32'(xfer_valid), 32'd0);
            tick();
        end
        launch(3, 4, 2, 1);
        scan_check("post rst", 3, 4, 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
